// File: rtl/addsub_pipe_if.sv
// Operand-issue / result-writeback bundle for addsub_pipe.
// The sat signal exists only when ADDSUB_PIPE_SATURATE_EN is defined.
interface addsub_pipe_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         cin;
`ifdef ADDSUB_PIPE_SATURATE_EN
    logic         sat;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         zero;
    logic         negative;

    modport master (
        output in_valid, a, b, sub, cin,
`ifdef ADDSUB_PIPE_SATURATE_EN
        output sat,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout, overflow, zero, negative
    );

    modport slave (
        input  in_valid, a, b, sub, cin,
`ifdef ADDSUB_PIPE_SATURATE_EN
        input  sat,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout, overflow, zero, negative
    );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined N-bit add/subtract: carry chain split into STAGES slices, one per cycle.
// Define ADDSUB_PIPE_SATURATE_EN to add a per-operation signed-saturation input (sat).
module addsub_pipe #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input logic          clk,
    input logic          reset,
    addsub_pipe_if.slave bus
);
    localparam int W = N / STAGES;

    // Valid/ready: a transfer happens on a port at any rising edge where valid and
    // ready are both high; the whole pipe moves together or holds together.
    logic advance;
    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    logic [STAGES-1:0] v_q, src_v;
    logic [STAGES-1:0] c_q, src_c, c_d;
    logic [N-1:0]      a_q   [STAGES];
    logic [N-1:0]      b_q   [STAGES];
    logic [N-1:0]      s_q   [STAGES];
    logic [N-1:0]      src_a [STAGES];
    logic [N-1:0]      src_b [STAGES];
    logic [N-1:0]      src_s [STAGES];
    logic [N-1:0]      a_d   [STAGES];
    logic [N-1:0]      b_d   [STAGES];
    logic [N-1:0]      s_d   [STAGES];
    logic [W:0]        part  [STAGES];
`ifdef ADDSUB_PIPE_SATURATE_EN
    logic              sat_q   [STAGES];
    logic              src_sat [STAGES];
`endif
    logic carry_msb, ovf_d, zero_d, neg_d;
    logic ovf_q, zero_q, neg_q;

    always_comb begin
        // Stage 0 sees the port; stage k sees the register of stage k-1.
        src_v[0] = bus.in_valid;
        src_a[0] = bus.a;
        src_b[0] = bus.b ^ {N{bus.sub}};
        src_s[0] = '0;
        src_c[0] = bus.sub ^ bus.cin;
`ifdef ADDSUB_PIPE_SATURATE_EN
        src_sat[0] = bus.sat;
`endif
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = v_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
`ifdef ADDSUB_PIPE_SATURATE_EN
            src_sat[k] = sat_q[k-1];
`endif
        end

        for (int k = 0; k < STAGES; k++) begin
            part[k] = {1'b0, src_a[k][k*W +: W]} + {1'b0, src_b[k][k*W +: W]}
                    + {{W{1'b0}}, src_c[k]};
            a_d[k] = src_a[k];
            b_d[k] = src_b[k];
            s_d[k] = src_s[k];
            s_d[k][k*W +: W] = part[k][W-1:0];
            c_d[k] = part[k][W];
        end

        // Carry into the MSB recovered from its sum bit and the two operand bits.
        carry_msb = s_d[STAGES-1][N-1] ^ a_d[STAGES-1][N-1] ^ b_d[STAGES-1][N-1];
        ovf_d     = carry_msb ^ c_d[STAGES-1];
`ifdef ADDSUB_PIPE_SATURATE_EN
        if (src_sat[STAGES-1] && ovf_d) begin
            s_d[STAGES-1] = a_d[STAGES-1][N-1] ? {1'b1, {(N-1){1'b0}}}
                                                : {1'b0, {(N-1){1'b1}}};
        end
`endif
        zero_d = (s_d[STAGES-1] == '0);
        neg_d  = s_d[STAGES-1][N-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
`ifdef ADDSUB_PIPE_SATURATE_EN
                sat_q[k] <= 1'b0;
`endif
            end
        end else if (advance) begin
            v_q    <= src_v;
            c_q    <= c_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
`ifdef ADDSUB_PIPE_SATURATE_EN
                sat_q[k] <= src_sat[k];
`endif
            end
        end
    end

    assign bus.out_valid = v_q[STAGES-1];
    assign bus.sum       = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = neg_q;
endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Pipelined, parametrised two's-complement adder/subtractor with valid/ready handshakes on input and output.
- The N-bit carry chain is split into STAGES equal slices, one slice per clock cycle, with carry registered between slices.
- Produces sum, carry-out, signed overflow, zero and negative flags.
- Sits between operand-issue logic and the result/flags writeback path of the ALU datapath.

Parameters:
- N, 32: operand and result width in bits. Must be ≥ 2.
- STAGES, 4: number of pipeline slices. Range 1..N, and N mod STAGES must equal 0. Slice width W = N/STAGES.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands are valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- sub  input  1  1 = A − B, 0 = A + B.
- cin  input  1  carry/borrow-in; effective carry into bit 0 is sub ^ cin.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  N  result.
- cout  output  1  carry out of bit N−1; for subtract, 1 = no borrow.
- overflow  output  1  signed overflow = (carry into bit N−1) ^ cout.
- zero  output  1  sum == 0.
- negative  output  1  sum[N−1].

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and reset.
- Reset: all stage valid bits clear. out_valid=0; sum, cout, overflow, zero, negative = 0. in_ready returns to 1 the first cycle after reset deasserts.
- Advance rule: advance = !out_valid || out_ready, evaluated combinationally. in_ready = advance.
  - Whole-pipe stall: when advance=0, every stage register holds.
  - Input transfer occurs on in_valid && in_ready.
- Stage 0 captures:
  - A.
  - B' = B ^ {N{sub}}.
  - Carry-in sub ^ cin.
  - Computes slice 0 (bits W−1:0).
- Stage k computes bits (k+1)W−1:kW, using the registered carry from stage k−1. Unprocessed upper operand bits and completed lower sum bits travel with the stage.
- Final stage:
  - Records carry into bit N−1 and carry out of bit N−1.
  - Flags are derived from the completed sum and registered alongside it.
- Latency: exactly STAGES cycles from input transfer to out_valid with no backpressure. Throughput is 1 result per cycle.
- Bubbles: a stage with no valid data propagates valid=0. Bubbles are not collapsed while stalled; the pipe advances only as a whole.
- Simultaneous out_ready and in_valid while full: the output transfers and a new input is accepted in the same cycle; no result is lost or duplicated.
- Output stability: while out_valid=1 and out_ready=0, sum and all flags hold stable.
- Reset mid-operation: in-flight results are discarded; no out_valid pulse follows.
- STAGES=1: purely registered single-cycle adder, same handshake.
- Width: all arithmetic is modulo 2^N. cout and overflow are computed as in a full N-bit ripple adder.

Optional Feature:
- Macro: ADDSUB_PIPE_SATURATE_EN.
- Defined:
  - Extra input sat (1 bit), captured with the operands.
  - When sat=1 and overflow=1, sum is clamped to the signed limit: 0111..1 if the true result is positive (A[N−1]=0), otherwise 1000..0.
  - overflow still reports 1; zero and negative are recomputed from the clamped sum.
  - Latency is unchanged; clamping is done in the final stage.
- Undefined: no sat port; wrap-around result only.

Test Plan (N=8, STAGES=2 unless stated):
- Reset, then a=0x05, b=0x03, sub=0, cin=0 → 2 cycles later out_valid=1, sum=0x08, cout=0, overflow=0, zero=0, negative=0.
- a=0x7F, b=0x01, add → sum=0x80, overflow=1, negative=1, cout=0. With macro and sat=1 → sum=0x7F, overflow=1, negative=0.
- a=0x03, b=0x03, sub=1, cin=0 → sum=0x00, zero=1, cout=1. Then a=0x00, b=0x01, sub=1 → sum=0xFF, cout=0, negative=1.
- Back-to-back stream of 10 random operand sets with out_ready=1 → 10 results in order, one per cycle after 2-cycle latency, each matching the reference model.
- Hold out_ready=0 for 5 cycles with in_valid=1 → in_ready drops once the output is valid; sum and flags stay stable. Release → all pending results are delivered in order with none lost.
- Assert reset with 2 results in flight → out_valid stays 0 through and after reset. N=16, STAGES=4: 0xFFFF+0x0001 → sum=0x0000, cout=1, zero=1, latency 4.
